// File: rtl/high_radix_div_pkg.sv
// Shared types and constants for the radix-4 restoring divider.
// Sized for a 32/16 signed divide beside the 16x16 multiplier.
package high_radix_div_pkg;

    localparam int DW    = 16;
    localparam int ITERS = DW / 2;
    localparam int REM_W = DW + 2;
    localparam int CNT_W = $clog2(ITERS);

    localparam logic [DW-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DW-1:0] Q_MIN = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/high_radix_div_digit_sel.sv
// Radix-4 digit selection: picks the largest k*dvs not exceeding t.
// The three multiples are compared in parallel.
module high_radix_div_digit_sel
    import high_radix_div_pkg::*;
(
    input  logic [REM_W-1:0] t,
    input  logic [DW-1:0]    dvs,
    output logic [1:0]       digit,
    output logic [DW-1:0]    next_rem
);

    logic [REM_W-1:0] d1;
    logic [REM_W-1:0] d2;
    logic [REM_W-1:0] d3;
    logic             ge1;
    logic             ge2;
    logic             ge3;

    assign d1  = {2'b00, dvs};
    assign d2  = {1'b0, dvs, 1'b0};
    assign d3  = d1 + d2;
    assign ge1 = t >= d1;
    assign ge2 = t >= d2;
    assign ge3 = t >= d3;

    // True remainder is below dvs, so 16-bit modular subtraction is exact
    always_comb begin
        digit    = 2'd0;
        next_rem = t[DW-1:0];
        unique case (1'b1)
            ge3: begin
                digit    = 2'd3;
                next_rem = t[DW-1:0] - d3[DW-1:0];
            end
            ge2 && !ge3: begin
                digit    = 2'd2;
                next_rem = t[DW-1:0] - d2[DW-1:0];
            end
            ge1 && !ge2: begin
                digit    = 2'd1;
                next_rem = t[DW-1:0] - d1[DW-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/high_radix_division.sv
// Iterative signed 32/16 divider, radix-4 restoring, two quotient bits
// per cycle, valid/ready on both sides, one operation in flight.
module high_radix_division
    import high_radix_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] x,
    input  logic [DW-1:0]   y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   q_o,
    output logic [DW-1:0]   r_o,
    output logic            dz_o,
    output logic            ovf_o
);

    state_t           state;
    state_t           state_nx;
    logic [2*DW-1:0]  x_r;
    logic [DW-1:0]    y_r;
    logic [2*DW-1:0]  abs_x;
    logic [DW-1:0]    abs_y;
    logic [DW-1:0]    dvs;
    logic [DW-1:0]    rem;
    logic [DW-1:0]    lo;
    logic [DW-1:0]    qreg;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;
    logic [REM_W-1:0] t;
    logic [1:0]       digit;
    logic [DW-1:0]    next_rem;
    logic             accept;
    logic             div_zero;
    logic             pre_ovf;
    logic             fix_ovf;
    logic             last_iter;

    assign abs_x     = x_r[2*DW-1] ? -x_r : x_r;
    assign abs_y     = y_r[DW-1] ? -y_r : y_r;
    assign div_zero  = y_r == '0;
    assign pre_ovf   = abs_x[2*DW-1:DW] >= abs_y;
    assign fix_ovf   = !sign_q && qreg[DW-1];
    assign last_iter = cnt == CNT_W'(ITERS - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign t         = {rem, lo[DW-1 -: 2]};

    high_radix_div_digit_sel u_digit (
        .t        (t),
        .dvs      (dvs),
        .digit    (digit),
        .next_rem (next_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = PREP;
            PREP: state_nx = (div_zero || pre_ovf) ? DONE : ITER;
            ITER: if (last_iter) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= '0;
            y_r    <= '0;
            dvs    <= '0;
            rem    <= '0;
            lo     <= '0;
            qreg   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            q_o    <= '0;
            r_o    <= '0;
            dz_o   <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        x_r   <= x;
                        y_r   <= y;
                        q_o   <= '0;
                        r_o   <= '0;
                        dz_o  <= 1'b0;
                        ovf_o <= 1'b0;
                    end
                end
                PREP: begin
                    sign_q <= x_r[2*DW-1] ^ y_r[DW-1];
                    sign_r <= x_r[2*DW-1];
                    dvs    <= abs_y;
                    rem    <= abs_x[2*DW-1:DW];
                    lo     <= abs_x[DW-1:0];
                    qreg   <= '0;
                    cnt    <= '0;
                    if (div_zero) begin
                        dz_o <= 1'b1;
                        q_o  <= '1;
                        r_o  <= x_r[DW-1:0];
                    end else if (pre_ovf) begin
                        ovf_o <= 1'b1;
                        q_o   <= (x_r[2*DW-1] ^ y_r[DW-1]) ? Q_MIN : Q_MAX;
                        r_o   <= '0;
                    end
                end
                ITER: begin
                    rem  <= next_rem;
                    lo   <= {lo[DW-3:0], 2'b00};
                    qreg <= {qreg[DW-3:0], digit};
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    if (fix_ovf) begin
                        ovf_o <= 1'b1;
                        q_o   <= Q_MAX;
                        r_o   <= '0;
                    end else begin
                        q_o <= sign_q ? -qreg : qreg;
                        r_o <= sign_r ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/high_radix_division.md
Name: high_radix_division

Overview:
Iterative signed divider, the inverse of the team's combinational 16x16 high-radix multiplier.
- Function: 32-bit dividend by 16-bit divisor, giving a 16-bit quotient and a 16-bit remainder.
- Method: radix-4 restoring; two quotient bits retired per cycle.
- Interfaces: valid/ready on both input and output; sits beside the multiplier in the arithmetic datapath.

Parameters:
- DW, 16, divisor/quotient/remainder width; dividend is 2*DW.
- ITERS, DW/2, radix-4 iterations; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept operands
- x  in  32  signed dividend
- y  in  16  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- q_o  out  16  signed quotient, truncated toward zero
- r_o  out  16  signed remainder, same sign as x
- dz_o  out  1  divide-by-zero flag
- ovf_o  out  1  quotient overflow flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; q_o=0, r_o=0, dz_o=0, ovf_o=0.
  - Reset mid-operation aborts the operation; no partial result is emitted.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready at an edge latches x, y -> PREP.
- PREP (1 cycle):
  - Compute |x| (32b unsigned) and |y| (16b unsigned); store sign_q = x[31]^y[31... i.e. y[15]] and sign_r = x[31].
  - y==0: dz_o=1, q_o=16'hFFFF, r_o=x[15:0] -> DONE.
  - Else if |x|[31:16] >= |y|: ovf_o=1, q_o = sign_q ? 16'h8000 : 16'h7FFF, r_o=0 -> DONE.
  - Else rem=|x|[31:16], cnt=0 -> ITER.
- ITER (exactly 8 cycles):
  - t = {rem, next 2 bits of |x|[15:0], MSB first}, 18 bits.
  - Digit d = largest k in {0,1,2,3} with t >= k*|y|; rem = t - d*|y|.
  - Append d to the quotient register; cnt++.
  - cnt==7 -> FIX.
- FIX (1 cycle):
  - Quotient magnitude Q: if sign_q=0 and Q>0x7FFF -> overflow handling as in PREP.
  - Otherwise q_o = sign_q ? -Q : Q and r_o = sign_r ? -rem : rem.
  - -> DONE.
- DONE:
  - out_valid=1; q_o, r_o, dz_o, ovf_o held stable while out_ready=0.
  - out_ready=1 at an edge -> IDLE.
  - in_ready=0 in DONE, so a new accept is never taken in the same cycle as result consumption.
- Latency:
  - Acceptance edge T; normal result has out_valid=1 in cycle T+11.
  - dz/ovf detected in PREP gives out_valid in cycle T+2.
  - Throughput: one operation in flight.
- in_ready=0 in PREP, ITER, FIX, DONE; in_valid there is ignored.
- Flags are mutually exclusive; both clear when the next operation is accepted.
- Arithmetic is all unsigned magnitude internally.
  - 3*|y| is 18 bits max (0x18000); comparisons are 18-bit.
  - Precheck guarantees rem < |y| on every iteration.

Decomposition:
- Package high_radix_div_pkg holds:
  - state enum {IDLE, PREP, ITER, FIX, DONE};
  - DW, ITERS, REM_W=DW+2;
  - saturation constants Q_MAX=16'h7FFF, Q_MIN=16'h8000.
- One combinational sub-module, high_radix_div_digit_sel:
  - Inputs: t[17:0], dvs[15:0].
  - Outputs: digit[1:0], next_rem[15:0].
  - Contains the three parallel compares against d, 2d, 3d.

Test Plan:
- x=100, y=7 -> q_o=14, r_o=2, flags 0, out_valid in cycle T+11.
- x=-100, y=7 -> q_o=-14 (0xFFF2), r_o=-2 (0xFFFE); x=100, y=-7 -> q_o=-14, r_o=2.
- x=32'hFFFF8000 (-32768), y=1 -> q_o=0x8000, ovf_o=0. x=32768, y=1 -> ovf_o=1, q_o=0x7FFF, caught in FIX.
- x=0x00010000, y=1 -> ovf_o=1, q_o=0x7FFF, r_o=0, out_valid at T+2. y=0, x=0x12345678 -> dz_o=1, q_o=0xFFFF, r_o=0x5678.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0. Then pulse out_ready -> IDLE, in_ready=1 next cycle.
- Assert rst_n=0 during ITER (cnt=3) -> immediate out_valid=0, in_ready=1, outputs 0. Next op x=1000, y=-33 -> q_o=-30, r_o=10.
